// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon game controller and its sequence memory.
package simon_pkg;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [1:0] color_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit right-shift Galois LFSR; steps on every clock out of reset.
module lfsr16 #(
  parameter logic [15:0] SEED = simon_pkg::LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);
  import simon_pkg::*;

  // An all-zero seed would lock the register, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED_EFF;
    end else begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/seq_store.sv
// Simon colour-sequence memory: register array with valid bits, length counter and
// an LFSR supplying the colour captured on each write.
module seq_store #(
  parameter int          DEPTH     = simon_pkg::DEPTH,
  parameter int          ADDR_W    = simon_pkg::ADDR_W,
  parameter logic [15:0] LFSR_SEED = simon_pkg::LFSR_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_data,
  output logic [1:0]        random_seq,
  output logic              entry_valid,
  output logic [ADDR_W:0]   seq_len,
  output logic              full
);
  import simon_pkg::*;

  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W + 1)'(DEPTH);

  logic [15:0]      lfsr_state;
  logic             lfsr_unused;
  color_t           entry [DEPTH];
  logic [DEPTH-1:0] valid;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state)
  );

  assign random_seq  = lfsr_state[1:0];
  assign lfsr_unused = ^lfsr_state[15:2];

  // Address 0 starts a new game: stale entries keep their data but lose validity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
      valid   <= '0;
      seq_len <= '0;
    end else if (mem_write) begin
      entry[mem_addr] <= random_seq;
      if (mem_addr == '0) begin
        valid   <= DEPTH'(1);
        seq_len <= (ADDR_W + 1)'(1);
      end else begin
        valid[mem_addr] <= 1'b1;
        if (!valid[mem_addr]) begin
          seq_len <= seq_len + 1'b1;
        end
      end
    end
  end

  always_comb begin
    entry_valid = valid[mem_addr];
    mem_data    = entry_valid ? entry[mem_addr] : 2'b00;
    full        = (seq_len == LEN_FULL);
  end

endmodule

// File: tb/tb_seq_store.sv
// Directed bench for seq_store: per-cycle comparison against a set-based model plus
// hand-computed checkpoints for reset, LFSR start-up, fill, overwrite and clear.
module tb_seq_store;
  localparam int          AW   = 5;
  localparam int          D    = 32;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [1:0]    mem_data;
  logic [1:0]    random_seq;
  logic          entry_valid;
  logic [AW:0]   seq_len;
  logic          full;

  seq_store #(.DEPTH(D), .ADDR_W(AW), .LFSR_SEED(SEED)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .random_seq  (random_seq),
    .entry_valid (entry_valid),
    .seq_len     (seq_len),
    .full        (full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the sequence as a set of valid slots; length is simply how many are valid.
  logic [15:0] m_lfsr;
  logic [1:0]  m_entry [D];
  bit          m_valid [D];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  function automatic int m_len();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = SEED;
      for (int i = 0; i < D; i++) begin
        m_entry[i] = 2'b00;
        m_valid[i] = 1'b0;
      end
    end else begin
      if (mem_write) begin
        m_entry[mem_addr] = m_lfsr[1:0];
        if (mem_addr == 0) begin
          for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
        end
        m_valid[mem_addr] = 1'b1;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("random_seq", random_seq, m_lfsr[1:0]);
      check("lfsr_state", u_dut.u_lfsr.state, m_lfsr);
      check("lfsr_nonzero", u_dut.u_lfsr.state != 16'h0, 1);
      check("entry_valid", entry_valid, m_valid[mem_addr]);
      check("mem_data", mem_data, m_valid[mem_addr] ? m_entry[mem_addr] : 2'b00);
      check("seq_len", seq_len, m_len());
      check("full", full, m_len() == D);
    end
  end

  task automatic wr(input logic [AW-1:0] a);
    mem_write = 1'b1;
    mem_addr  = a;
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    mem_addr = a;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // First cycle after release: write address 0 while reading it.
    rst = 1'b0; mem_write = 1'b1; mem_addr = '0;
    #1;
    check("lfsr_c1", random_seq, 2'b01);
    check("same_cycle_rd", mem_data, 2'b00);
    check("same_cycle_vld", entry_valid, 1'b0);
    check("len_before_wr", seq_len, 0);
    @(posedge clk); #1;
    mem_write = 1'b0;
    #1;
    check("lfsr_c2", random_seq, 2'b00);
    check("rd_after_wr0", mem_data, 2'b01);
    check("vld_after_wr0", entry_valid, 1'b1);
    check("len_after_wr0", seq_len, 1);
    @(posedge clk); #2;
    check("lfsr_c3", random_seq, 2'b00);
    check("model_pin", m_lfsr, 16'h7138);

    for (int i = 0; i < D; i++) wr(AW'(i));
    #1;
    check("fill_full", full, 1'b1);
    check("fill_len", seq_len, 32);
    for (int i = 0; i < D; i++) rd(AW'(i));

    wr(AW'(5));
    mem_addr = AW'(5);
    #1;
    check("ovw_len", seq_len, 32);
    check("ovw_full", full, 1'b1);
    check("ovw_vld", entry_valid, 1'b1);
    wr('0);
    mem_addr = AW'(5);
    #1;
    check("clr_len", seq_len, 1);
    check("clr_full", full, 1'b0);
    check("clr_data5", mem_data, 2'b00);
    check("clr_vld5", entry_valid, 1'b0);
    mem_addr = AW'(7);
    #1;
    check("unw_data7", mem_data, 2'b00);
    check("unw_vld7", entry_valid, 1'b0);
    wr(AW'(7));
    #1;
    check("gap_len", seq_len, 2);
    rd(AW'(7));
    wr(AW'(7));
    wr(AW'(3));

    // Asynchronous reset in the middle of a cycle.
    mem_addr = '0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_len", seq_len, 0);
    check("rst_full", full, 1'b0);
    check("rst_data", mem_data, 2'b00);
    check("rst_vld", entry_valid, 1'b0);
    check("rst_rseq", random_seq, 2'b01);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      if (i % 7 == 3) wr(AW'(i * 3));
      else rd(AW'(i));
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_store.md
# seq_store

Sequence-memory responder for the Simon game controller. Answers the controller's `mem_write` / `mem_addr` / `mem_data` port: it holds the colour sequence and produces the `random_seq` colour that each write captures. A free-running LFSR supplies the randomness, so the sequence depends on player timing. The block sits beside the game FSM at top level and is its only memory.

## Interface
- `DEPTH`, default 32: sequence entries; must equal 2**`ADDR_W`.
- `ADDR_W`, default 5: address width; matches the controller's `mem_addr`.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `mem_write`, input, 1: write strobe from the controller.
- `mem_addr`, input, `ADDR_W`: read/write address.
- `mem_data`, output, 2: colour stored at `mem_addr`; combinational read.
- `random_seq`, output, 2: current random colour, equal to `lfsr[1:0]`.
- `entry_valid`, output, 1: the entry at `mem_addr` has been written since the last clear.
- `seq_len`, output, `ADDR_W`+1: count of valid entries, range 0..32.
- `full`, output, 1: high when `seq_len` == `DEPTH`.

## Operation
- **LFSR:** 16-bit Galois, right-shift, taps 16'hB400. It advances every cycle out of reset: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It never reaches zero.
- **Write:** when `mem_write`=1 at an edge:
  - `entry[mem_addr]` <= `random_seq` (value before the edge).
  - `valid[mem_addr]` <= 1.
- **New-game clear:** a write to address 0 sets `valid` to 32'h1 and `seq_len` to 1. Stale entries 1..31 keep their data but are invalidated.
- **Write to any other address:**
  - If the entry was invalid: `seq_len` increments.
  - If it was already valid: it is overwritten and `seq_len` is unchanged.
- **Read:**
  - `mem_data` = `entry[mem_addr]` when `valid[mem_addr]`, else 2'b00.
  - `entry_valid` = `valid[mem_addr]`.
  - Both are purely combinational from `mem_addr` and the registered state.
- **Write/read on the same address in the same cycle:** read returns the pre-write contents. There is no write-through.
- `seq_len` saturates at 32 by construction. `full` is derived combinationally from `seq_len`.
- **Writes while full:** writes to valid addresses overwrite; `seq_len` stays 32. A write to address 0 while full still clears.

## Timing
- **Reset values:**
  - lfsr = `LFSR_SEED`, so `random_seq` = 2'b01 with the default seed.
  - All entries 0; `valid` = 0.
  - `seq_len` = 0, `full` = 0.
  - `mem_data` = 0, `entry_valid` = 0.
- Reset asserted mid-game clears everything immediately, without waiting for a clock edge. The first edge after release steps the LFSR once.
- **Write latency:** 1 cycle. Data is readable at the same address from the cycle after the write edge.
- **Read latency:** 0 cycles (combinational). The controller's one-cycle play/validate states rely on this.
- `random_seq` changes every cycle. The captured value is the one present during the cycle `mem_write` is high.
- There is no handshake. Every `mem_write` cycle is accepted, and back-to-back writes are legal.

## Structure
- **Package `simon_pkg`** holds:
  - `ADDR_W`, `DEPTH`
  - `typedef logic [1:0] color_t`
  - `LFSR_TAPS` = 16'hB400 and `LFSR_SEED_DEFAULT` = 16'hACE1
- The game FSM and `seq_store` both import the package.
- **Sub-module `lfsr16`:** ports `clk`, `rst`, seed parameter, 16-bit `state` output. It steps every cycle.
- Storage is a 32x2 register array plus a 32-bit valid vector and the `seq_len` counter. No RAM macro is used, because the read is asynchronous.

## Test plan
1. **Reset:** assert `rst` mid-run with entries written → immediately `seq_len`=0, `full`=0, `mem_data`=0, `random_seq`=2'b01.
2. **LFSR:** release reset, sample `random_seq` over 3 cycles → 2'b01, 2'b00, 2'b00 (lfsr 16'hACE1, 16'hE270, 16'h7138). Compare 1000 steps against a reference model; lfsr never 0.
3. **Write/read:**
   - Write addr 0 in the first cycle after release → next cycle `mem_data`=2'b01, `entry_valid`=1, `seq_len`=1.
   - Same-cycle read of addr 0 during that write → 2'b00.
4. **Fill:** write addrs 0..31 consecutively → `seq_len` steps 1..32, `full`=1 after the 32nd write. Each `mem_data` readback matches the captured `random_seq`.
5. **Overwrite and clear:**
   - While full, write addr 5 → `seq_len` stays 32 and the data is updated.
   - Then write addr 0 → `seq_len`=1, `full`=0. Addr 5 reads `mem_data`=0, `entry_valid`=0.
6. **Invalid read and gap write:** read an unwritten addr 7 → 0/0. Write addr 7 without writing 1..6 → `seq_len` increments by 1.
